// File: rtl/peripheral_dbg_pu_riscv_biu_burst_ctrl_if.sv
// Bundle of command, data-stream, status and BIU signals around the debug burst sequencer.
// The slave modport is the sequencer's view; master is the debug module plus bridge side.
interface peripheral_dbg_pu_riscv_biu_burst_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic [3:0]            cmd_word_size;
    logic                  cmd_write;
    logic                  abort;

    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_ready;

    logic                  busy;
    logic                  done;
    logic                  err;
    logic [LEN_WIDTH-1:0]  beats;

    logic                  biu_strb;
    logic                  biu_rw;
    logic [ADDR_WIDTH-1:0] biu_addr;
    logic [DATA_WIDTH-1:0] biu_di;
    logic [3:0]            biu_word_size;
    logic                  biu_rdy;
    logic [DATA_WIDTH-1:0] biu_do;
    logic                  biu_err;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, cmd_word_size, cmd_write, abort,
        input  wr_data, wr_valid, rd_ready,
        input  biu_rdy, biu_do, biu_err,
        output cmd_ready, wr_ready, rd_data, rd_valid,
        output busy, done, err, beats,
        output biu_strb, biu_rw, biu_addr, biu_di, biu_word_size
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_len, cmd_word_size, cmd_write, abort,
        output wr_data, wr_valid, rd_ready,
        output biu_rdy, biu_do, biu_err,
        input  cmd_ready, wr_ready, rd_data, rd_valid,
        input  busy, done, err, beats,
        input  biu_strb, biu_rw, biu_addr, biu_di, biu_word_size
    );
endinterface

// File: rtl/peripheral_dbg_pu_riscv_biu_burst_ctrl.sv
// Debug-module burst sequencer: expands one burst command into back-to-back single BIU
// accesses, streaming write data in and read data out, with completion and sticky error status.
module peripheral_dbg_pu_riscv_biu_burst_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input logic                                    biu_clk,
    input logic                                    biu_rst,
    peripheral_dbg_pu_riscv_biu_burst_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_FETCH   = 3'd2,
        ST_STROBE  = 3'd3,
        ST_WAIT    = 3'd4,
        ST_DELIVER = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    state_t                state_r, state_s;

    logic [ADDR_WIDTH-1:0] addr_r, addr_s;
    logic                  rw_r, rw_s;
    logic [3:0]            ws_r, ws_s;
    logic [DATA_WIDTH-1:0] di_r, di_s;
    logic [DATA_WIDTH-1:0] rd_data_r, rd_data_s;
    logic [LEN_WIDTH-1:0]  beats_r, beats_s;
    logic [LEN_WIDTH-1:0]  len_r, len_s;
    logic                  err_r, err_s;

    logic                  cmd_ready_r;
    logic                  busy_r;
    logic                  wr_ready_r;
    logic                  rd_valid_r;
    logic                  strb_r;
    logic                  done_r;

    // Word size must be a power of two the data path can carry, and the address aligned to it.
    function automatic logic cmd_illegal(input logic [3:0] ws, input logic [ADDR_WIDTH-1:0] addr);
        logic                  size_bad;
        logic [ADDR_WIDTH-1:0] mask;
        case (ws)
            4'd1, 4'd2, 4'd4: size_bad = 1'b0;
            4'd8:             size_bad = (DATA_WIDTH == 64) ? 1'b0 : 1'b1;
            default:          size_bad = 1'b1;
        endcase
        mask = ADDR_WIDTH'(ws) - ADDR_WIDTH'(1'b1);
        return size_bad | ((addr & mask) != '0);
    endfunction

    // Next-state and next-datapath decode for the burst sequencer.
    always_comb begin
        state_s   = state_r;
        addr_s    = addr_r;
        rw_s      = rw_r;
        ws_s      = ws_r;
        di_s      = di_r;
        rd_data_s = rd_data_r;
        beats_s   = beats_r;
        len_s     = len_r;
        err_s     = err_r;

        case (state_r)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    addr_s  = bus.cmd_addr;
                    rw_s    = ~bus.cmd_write;
                    ws_s    = bus.cmd_word_size;
                    len_s   = bus.cmd_len;
                    beats_s = '0;
                    err_s   = 1'b0;
                    state_s = ST_CHECK;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (cmd_illegal(ws_r, addr_r)) begin
                    err_s   = 1'b1;
                    state_s = ST_DONE;
                end else if ((len_r == '0) || bus.abort) begin
                    state_s = ST_DONE;
                end else if (rw_r) begin
                    state_s = ST_STROBE;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (bus.abort) begin
                    state_s = ST_DONE;
                end else if (bus.wr_valid) begin
                    di_s    = bus.wr_data;
                    state_s = ST_STROBE;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_STROBE: begin
                if (bus.biu_rdy) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_STROBE;
                end
            end
            ST_WAIT: begin
                // Abort is deliberately not looked at here: the bus access must finish first.
                if (bus.biu_rdy) begin
                    beats_s = beats_r + LEN_WIDTH'(1'b1);
                    if (bus.biu_err) begin
                        err_s   = 1'b1;
                        state_s = ST_DONE;
                    end else if (rw_r) begin
                        rd_data_s = bus.biu_do;
                        state_s   = ST_DELIVER;
                    end else if (beats_s == len_r) begin
                        state_s = ST_DONE;
                    end else begin
                        addr_s  = addr_r + ADDR_WIDTH'(ws_r);
                        state_s = ST_FETCH;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DELIVER: begin
                if (bus.rd_ready) begin
                    if ((beats_r == len_r) || bus.abort) begin
                        state_s = ST_DONE;
                    end else begin
                        addr_s  = addr_r + ADDR_WIDTH'(ws_r);
                        state_s = ST_STROBE;
                    end
                end else begin
                    state_s = ST_DELIVER;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge biu_clk or posedge biu_rst) begin
        if (biu_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath registers and state-decoded outputs, registered off the next state.
    always_ff @(posedge biu_clk or posedge biu_rst) begin
        if (biu_rst) begin
            addr_r      <= '0;
            rw_r        <= 1'b1;
            ws_r        <= 4'd4;
            di_r        <= '0;
            rd_data_r   <= '0;
            beats_r     <= '0;
            len_r       <= '0;
            err_r       <= 1'b0;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            wr_ready_r  <= 1'b0;
            rd_valid_r  <= 1'b0;
            strb_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            addr_r      <= addr_s;
            rw_r        <= rw_s;
            ws_r        <= ws_s;
            di_r        <= di_s;
            rd_data_r   <= rd_data_s;
            beats_r     <= beats_s;
            len_r       <= len_s;
            err_r       <= err_s;
            cmd_ready_r <= (state_s == ST_IDLE);
            busy_r      <= (state_s != ST_IDLE);
            wr_ready_r  <= (state_s == ST_FETCH);
            rd_valid_r  <= (state_s == ST_DELIVER);
            strb_r      <= (state_s == ST_STROBE);
            done_r      <= (state_s == ST_DONE);
        end
    end

    assign bus.cmd_ready     = cmd_ready_r;
    assign bus.busy          = busy_r;
    assign bus.done          = done_r;
    assign bus.err           = err_r;
    assign bus.beats         = beats_r;
    assign bus.wr_ready      = wr_ready_r;
    assign bus.rd_valid      = rd_valid_r;
    assign bus.rd_data       = rd_data_r;
    assign bus.biu_strb      = strb_r;
    assign bus.biu_rw        = rw_r;
    assign bus.biu_addr      = addr_r;
    assign bus.biu_di        = di_r;
    assign bus.biu_word_size = ws_r;

endmodule

// File: tb/tb_peripheral_dbg_pu_riscv_biu_burst_ctrl.sv
// Bench for the debug burst sequencer: bridge responder, bus monitor and a burst-level
// reference model (address list, beat/error counts) checked with immediate assertions.
module tb_peripheral_dbg_pu_riscv_biu_burst_ctrl;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 16;

    logic biu_clk = 1'b0;
    logic biu_rst;

    peripheral_dbg_pu_riscv_biu_burst_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    peripheral_dbg_pu_riscv_biu_burst_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .biu_clk (biu_clk),
        .biu_rst (biu_rst),
        .bus     (bus)
    );

    always #5 biu_clk = ~biu_clk;

    int vectors     = 0;
    int miscompares = 0;

    int            br_lat      = 3;
    int            br_err_beat = 0;
    int            br_cnt      = 0;
    logic          br_read     = 1'b1;
    logic          br_e        = 1'b0;
    logic [DW-1:0] br_data     = '0;

    logic [AW-1:0] s_addr[$];
    logic          s_rw[$];
    logic [3:0]    s_ws[$];
    logic [DW-1:0] s_di[$];
    logic [DW-1:0] got_rd[$];
    logic [DW-1:0] exp_rd[$];
    logic [DW-1:0] exp_wr[$];
    int            done_cnt = 0;
    int            strb_cyc = 0;

    // Bridge: accept strobe while ready, drop ready, return random data after br_lat cycles.
    always @(posedge biu_clk or posedge biu_rst) begin
        if (biu_rst) begin
            bus.biu_rdy <= 1'b1;
            bus.biu_do  <= '0;
            bus.biu_err <= 1'b0;
            br_cnt      <= 0;
        end else if (bus.biu_rdy) begin
            if (bus.biu_strb) begin
                bus.biu_rdy <= 1'b0;
                bus.biu_err <= 1'b0;
                br_cnt      <= br_lat;
                br_read     <= bus.biu_rw;
            end
        end else if (br_cnt <= 1) begin
            br_data = $urandom;
            br_e    = (br_err_beat != 0) && (s_addr.size() == br_err_beat);
            bus.biu_rdy <= 1'b1;
            bus.biu_do  <= br_data;
            bus.biu_err <= br_e;
            if (br_read && !br_e) exp_rd.push_back(br_data);
        end else begin
            br_cnt <= br_cnt - 1;
        end
    end

    // Monitor: record accepted strobes, delivered read beats and done pulses mid-cycle.
    always @(negedge biu_clk) begin
        if (bus.biu_strb) strb_cyc++;
        if (bus.biu_strb && bus.biu_rdy) begin
            s_addr.push_back(bus.biu_addr);
            s_rw.push_back(bus.biu_rw);
            s_ws.push_back(bus.biu_word_size);
            s_di.push_back(bus.biu_di);
        end
        if (bus.rd_valid && bus.rd_ready) got_rd.push_back(bus.rd_data);
        if (bus.done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_cmd_ready"}, bus.cmd_ready, 1);
        chk({nm, "_busy"}, bus.busy, 0);
        chk({nm, "_done"}, bus.done, 0);
        chk({nm, "_err"}, bus.err, 0);
        chk({nm, "_beats"}, bus.beats, 0);
        chk({nm, "_rd_valid"}, bus.rd_valid, 0);
        chk({nm, "_wr_ready"}, bus.wr_ready, 0);
        chk({nm, "_strb"}, bus.biu_strb, 0);
        chk({nm, "_rw"}, bus.biu_rw, 1);
        chk({nm, "_addr"}, bus.biu_addr, 0);
        chk({nm, "_di"}, bus.biu_di, 0);
        chk({nm, "_ws"}, bus.biu_word_size, 4);
        chk({nm, "_rd_data"}, bus.rd_data, 0);
    endtask

    task automatic clear_logs();
        s_addr.delete(); s_rw.delete(); s_ws.delete(); s_di.delete();
        got_rd.delete(); exp_rd.delete(); exp_wr.delete();
        done_cnt = 0;
        strb_cyc = 0;
    endtask

    task automatic issue(input logic [AW-1:0] addr, input int len, input int ws, input bit wr);
        bus.cmd_addr      = addr;
        bus.cmd_len       = LW'(len);
        bus.cmd_word_size = 4'(ws);
        bus.cmd_write     = wr;
        bus.cmd_valid     = 1'b1;
        @(posedge biu_clk); #2;
        bus.cmd_valid     = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        for (int c = 0; c < 3000 && done_cnt == 0; c++) @(negedge biu_clk);
        repeat (3) @(negedge biu_clk);
        chk({nm, "_done_pulses"}, done_cnt, 1);
        chk({nm, "_idle_ready"}, bus.cmd_ready, 1);
        chk({nm, "_idle_busy"}, bus.busy, 0);
    endtask

    // One burst end to end; expectations come from burst-level arithmetic, not cycle timing.
    task automatic run_burst(input string nm, input logic [AW-1:0] addr, input int len, input int ws,
                             input bit wr, input int lat, input int eb, input int gap);
        bit            illegal, err_exp, hs;
        int            n_acc, n_rd;
        logic [DW-1:0] d;
        logic [AW-1:0] ea;
        illegal = !(ws == 1 || ws == 2 || ws == 4);
        if (!illegal) illegal = (addr % AW'(ws)) != '0;
        err_exp = illegal || (eb >= 1 && eb <= len);
        n_acc   = (illegal || len == 0) ? 0 : (err_exp ? eb : len);
        n_rd    = wr ? 0 : ((err_exp && n_acc > 0) ? n_acc - 1 : n_acc);

        clear_logs();
        br_lat      = lat;
        br_err_beat = eb;
        issue(addr, len, ws, wr);
        chk({nm, "_busy"}, bus.busy, 1);
        if (wr) begin
            for (int b = 0; b < n_acc; b++) begin
                for (int g = 0; g < gap; g++) begin @(posedge biu_clk); #2; end
                d = $urandom;
                bus.wr_data  = d;
                bus.wr_valid = 1'b1;
                hs = 1'b0;
                for (int c = 0; c < 500 && !hs; c++) begin
                    @(negedge biu_clk);
                    hs = bus.wr_ready;
                end
                @(posedge biu_clk); #2;
                bus.wr_valid = 1'b0;
                chk($sformatf("%s_wr_hs%0d", nm, b), hs, 1);
                if (!hs) break;
                exp_wr.push_back(d);
            end
        end
        wait_done(nm);
        chk({nm, "_err"}, bus.err, err_exp);
        chk({nm, "_beats"}, bus.beats, n_acc);
        chk({nm, "_n_strobes"}, s_addr.size(), n_acc);
        chk({nm, "_strb_cycles"}, strb_cyc, n_acc);
        for (int i = 0; i < n_acc && i < s_addr.size(); i++) begin
            ea = addr + AW'(i * ws);
            chk($sformatf("%s_addr%0d", nm, i), s_addr[i], ea);
            chk($sformatf("%s_rw%0d", nm, i), s_rw[i], !wr);
            chk($sformatf("%s_ws%0d", nm, i), s_ws[i], ws);
            if (wr && i < exp_wr.size()) chk($sformatf("%s_di%0d", nm, i), s_di[i], exp_wr[i]);
        end
        chk({nm, "_n_rd"}, got_rd.size(), n_rd);
        for (int i = 0; i < got_rd.size() && i < exp_rd.size(); i++)
            chk($sformatf("%s_rd%0d", nm, i), got_rd[i], exp_rd[i]);
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] snap;
        int            ws, len, eb;
        bit            wr;

        biu_rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0; bus.cmd_word_size = 4'd4;
        bus.cmd_write = 1'b0; bus.abort = 1'b0; bus.wr_data = '0; bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b1;
        repeat (3) @(posedge biu_clk); #2;
        chk_reset("rst_in");
        biu_rst = 1'b0;
        @(posedge biu_clk); #2;
        chk_reset("rst_out");

        run_burst("rd4", 32'h0000_0100, 4, 4, 1'b0, 3, 0, 0);
        run_burst("wr3", 32'h0000_2002, 3, 2, 1'b1, 3, 0, 2);
        run_burst("rderr", 32'h0000_4000, 5, 4, 1'b0, 2, 2, 0);
        run_burst("ill_align", 32'h0000_0003, 2, 4, 1'b0, 3, 0, 0);
        run_burst("ill_size8", 32'h0000_1000, 2, 8, 1'b0, 3, 0, 0);
        run_burst("len0", 32'h0000_1000, 0, 4, 1'b0, 3, 0, 0);

        // Backpressure on beat 1, then abort raised while beat 2 is on the bus.
        clear_logs();
        br_lat = 2; br_err_beat = 0;
        bus.rd_ready = 1'b0;
        a = $urandom & 32'hFFFF_FFF0;
        issue(a, 6, 4, 1'b0);
        for (int c = 0; c < 500 && !bus.rd_valid; c++) @(negedge biu_clk);
        snap = bus.rd_data;
        chk("bp_first_data", snap, (exp_rd.size() > 0) ? exp_rd[0] : ~snap);
        for (int c = 0; c < 10; c++) begin
            @(negedge biu_clk);
            chk($sformatf("bp_valid%0d", c), bus.rd_valid, 1);
            chk($sformatf("bp_data%0d", c), bus.rd_data, snap);
            chk($sformatf("bp_nostrb%0d", c), s_addr.size(), 1);
        end
        @(posedge biu_clk); #2;
        bus.rd_ready = 1'b1;
        for (int c = 0; c < 500 && s_addr.size() < 2; c++) @(negedge biu_clk);
        @(posedge biu_clk); #2;
        bus.abort = 1'b1;
        wait_done("abort");
        bus.abort = 1'b0;
        chk("abort_beats", bus.beats, 2);
        chk("abort_err", bus.err, 0);
        chk("abort_n_strobes", s_addr.size(), 2);
        chk("abort_addr1", (s_addr.size() > 1) ? s_addr[1] : 32'h0, a + 32'd4);
        chk("abort_n_rd", got_rd.size(), 2);
        for (int i = 0; i < got_rd.size() && i < exp_rd.size(); i++)
            chk($sformatf("abort_rd%0d", i), got_rd[i], exp_rd[i]);

        for (int k = 0; k < 8; k++) begin
            ws  = 1 << $urandom_range(0, 2);
            a   = $urandom;
            a   = a - (a % AW'(ws));
            len = $urandom_range(1, 5);
            wr  = 1'($urandom_range(0, 1));
            eb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, len)) : 0;
            run_burst($sformatf("rnd%0d", k), a, len, ws, wr,
                      int'($urandom_range(1, 4)), eb, int'($urandom_range(0, 2)));
        end

        run_burst("wrap", 32'hFFFF_FFFC, 2, 4, 1'b0, 1, 0, 0);

        // Reset while the first access of a read burst is outstanding.
        clear_logs();
        br_lat = 4; br_err_beat = 0;
        issue(32'h0000_8000, 3, 4, 1'b0);
        for (int c = 0; c < 500 && s_addr.size() < 1; c++) @(negedge biu_clk);
        @(posedge biu_clk); #2;
        chk("mid_busy", bus.busy, 1);
        biu_rst = 1'b1;
        #1;
        chk_reset("mid_rst");
        @(posedge biu_clk); #2;
        biu_rst = 1'b0;
        #1;
        chk("post_rst_ready", bus.cmd_ready, 1);
        @(posedge biu_clk); #2;
        run_burst("post_rst", 32'h0000_0040, 2, 1, 1'b1, 2, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
